// File: rtl/div_req_sequencer_if.sv
// Bundle between the hue logic, the div_gen_0 channels and the response consumer.
// Optional DIV_PERF_CNT_EN adds the cnt_issued / cnt_dbz counters.
interface div_req_sequencer_if #(
  parameter int TAG_W = 4
);
  // Handshake rule (req and rsp): a transfer happens on a rising clk edge where
  // valid && ready; valid and payload hold until accepted, and ready never waits on valid.
  // The divider channels have no ready: a tvalid pulse is always consumed.
  logic             req_valid;
  logic             req_ready;
  logic [8:0]       req_dividend;
  logic [7:0]       req_divisor;
  logic [TAG_W-1:0] req_tag;

  logic [7:0]       div_dividend_tdata;
  logic             div_dividend_tvalid;
  logic [7:0]       div_divisor_tdata;
  logic             div_divisor_tvalid;
  logic [15:0]      div_dout_tdata;
  logic             div_dout_tvalid;
  logic             div_dout_tuser;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [16:0]      rsp_result;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_dbz;

  logic             err_spurious;
`ifdef DIV_PERF_CNT_EN
  logic [15:0]      cnt_issued;
  logic [15:0]      cnt_dbz;
`endif

  modport master (
    output req_valid, req_dividend, req_divisor, req_tag, rsp_ready,
    output div_dout_tdata, div_dout_tvalid, div_dout_tuser,
    input  req_ready, div_dividend_tdata, div_dividend_tvalid,
    input  div_divisor_tdata, div_divisor_tvalid,
    input  rsp_valid, rsp_result, rsp_tag, rsp_dbz, err_spurious
`ifdef DIV_PERF_CNT_EN
    , input cnt_issued, cnt_dbz
`endif
  );

  modport slave (
    input  req_valid, req_dividend, req_divisor, req_tag, rsp_ready,
    input  div_dout_tdata, div_dout_tvalid, div_dout_tuser,
    output req_ready, div_dividend_tdata, div_dividend_tvalid,
    output div_divisor_tdata, div_divisor_tvalid,
    output rsp_valid, rsp_result, rsp_tag, rsp_dbz, err_spurious
`ifdef DIV_PERF_CNT_EN
    , output cnt_issued, cnt_dbz
`endif
  );
endinterface

// File: rtl/div_req_sequencer.sv
// Credit-based request sequencer around div_gen_0: issues magnitudes, restores sign,
// returns tagged Q9.8 results in order. Optional macro: DIV_PERF_CNT_EN (perf counters).
module div_req_sequencer #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 4
) (
  input logic                clk,
  input logic                rstn,
  div_req_sequencer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] MAX_CREDITS = (AW+1)'(DEPTH);

  logic [AW:0] credits;
  logic        req_fire, rsp_fire;
  logic [8:0]  mag9;
  logic [7:0]  mag;

  // Sideband FIFO: tag and sign of each op waiting on the divider.
  logic [TAG_W-1:0] sb_tag [DEPTH];
  logic             sb_neg [DEPTH];
  logic [AW:0]      sb_wr, sb_rd;
  logic             sb_empty;

  // Result FIFO: everything the response port presents.
  logic [TAG_W-1:0] rf_tag [DEPTH];
  logic             rf_dbz [DEPTH];
  logic [16:0]      rf_res [DEPTH];
  logic [AW:0]      rf_wr, rf_rd;
  logic             rf_empty, rf_full;

  logic        cap_ok, spurious, overflow, rf_we;
  logic [16:0] mag17, cap_res;
  logic        issue_v;
  logic [7:0]  issue_dd, issue_ds;
  logic        err_q;

  // Gating with rstn keeps every output low while reset is held.
  assign bus.req_ready = rstn && (credits < MAX_CREDITS);
  assign req_fire      = bus.req_valid && bus.req_ready;
  assign rsp_fire      = bus.rsp_valid && bus.rsp_ready;

  // -256 has no 8-bit magnitude, so it saturates to 255.
  assign mag9 = bus.req_dividend[8] ? (~bus.req_dividend + 9'd1) : bus.req_dividend;
  assign mag  = mag9[8] ? 8'hFF : mag9[7:0];

  assign sb_empty = (sb_wr == sb_rd);
  assign rf_empty = (rf_wr == rf_rd);
  assign rf_full  = (rf_wr[AW] != rf_rd[AW]) && (rf_wr[AW-1:0] == rf_rd[AW-1:0]);

  assign spurious = bus.div_dout_tvalid && sb_empty;
  assign cap_ok   = bus.div_dout_tvalid && !sb_empty;
  assign overflow = cap_ok && rf_full && !rsp_fire;
  assign rf_we    = cap_ok && !overflow;

  assign mag17   = {1'b0, bus.div_dout_tdata};
  assign cap_res = bus.div_dout_tuser ? 17'd0 :
                   (sb_neg[sb_rd[AW-1:0]] ? (17'd0 - mag17) : mag17);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      issue_v  <= 1'b0;
      issue_dd <= 8'd0;
      issue_ds <= 8'd0;
    end else if (req_fire) begin
      issue_v  <= 1'b1;
      issue_dd <= mag;
      issue_ds <= bus.req_divisor;
    end else begin
      issue_v  <= 1'b0;
      issue_dd <= 8'd0;
      issue_ds <= 8'd0;
    end
  end

  assign bus.div_dividend_tvalid = issue_v;
  assign bus.div_divisor_tvalid  = issue_v;
  assign bus.div_dividend_tdata  = issue_dd;
  assign bus.div_divisor_tdata   = issue_ds;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      credits <= '0;
      sb_wr   <= '0;
      sb_rd   <= '0;
      rf_wr   <= '0;
      rf_rd   <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case ({req_fire, rsp_fire})
        2'b10:   credits <= credits + 1'b1;
        2'b01:   credits <= credits - 1'b1;
        default: credits <= credits;
      endcase
      if (req_fire) sb_wr <= sb_wr + 1'b1;
      if (cap_ok)   sb_rd <= sb_rd + 1'b1;
      if (rf_we)    rf_wr <= rf_wr + 1'b1;
      if (rsp_fire) rf_rd <= rf_rd + 1'b1;
      if (spurious || overflow) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) begin
      sb_tag[sb_wr[AW-1:0]] <= bus.req_tag;
      sb_neg[sb_wr[AW-1:0]] <= bus.req_dividend[8];
    end
    if (rf_we) begin
      rf_tag[rf_wr[AW-1:0]] <= sb_tag[sb_rd[AW-1:0]];
      rf_dbz[rf_wr[AW-1:0]] <= bus.div_dout_tuser;
      rf_res[rf_wr[AW-1:0]] <= cap_res;
    end
  end

  assign bus.rsp_valid    = !rf_empty;
  assign bus.rsp_result   = rf_empty ? 17'd0 : rf_res[rf_rd[AW-1:0]];
  assign bus.rsp_tag      = rf_empty ? '0 : rf_tag[rf_rd[AW-1:0]];
  assign bus.rsp_dbz      = rf_empty ? 1'b0 : rf_dbz[rf_rd[AW-1:0]];
  assign bus.err_spurious = err_q;

`ifdef DIV_PERF_CNT_EN
  logic [15:0] cnt_issued_q, cnt_dbz_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_issued_q <= 16'd0;
      cnt_dbz_q    <= 16'd0;
    end else begin
      if (req_fire)                         cnt_issued_q <= cnt_issued_q + 16'd1;
      if (cap_ok && bus.div_dout_tuser)     cnt_dbz_q    <= cnt_dbz_q + 16'd1;
    end
  end

  assign bus.cnt_issued = cnt_issued_q;
  assign bus.cnt_dbz    = cnt_dbz_q;
`endif
endmodule

// File: tb/tb_div_req_sequencer.sv
// Randomized scoreboard bench for div_req_sequencer with a latency-LAT divider stand-in.
module tb_div_req_sequencer;
  localparam int DEPTH = 8;
  localparam int TAG_W = 4;
  localparam int LAT   = 3;
  localparam int W     = TAG_W + 18;

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  div_req_sequencer_if #(.TAG_W(TAG_W)) bus ();

  div_req_sequencer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // ---------------- scoreboard state ----------------
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [W-1:0] exp_q[$];
  int          credits_m = 0;
  int          sb_m      = 0;
  logic        exp_err   = 1'b0;
  logic        pend_v    = 1'b0;
  logic [7:0]  pend_mag, pend_dvs;
  logic        prev_stall = 1'b0;
  logic [W-1:0] prev_rsp;
  logic        p_v [LAT];
  logic [7:0]  p_d [LAT];
  logic [7:0]  p_s [LAT];
  int          spur_cnt  = 0;
  int          spur_done = 0;
  int          tmo       = 0;
  logic        end_chk   = 1'b0;
  logic        fin       = 1'b0;
`ifdef DIV_PERF_CNT_EN
  logic [15:0] issued_m = 16'd0;
  logic [15:0] dbz_m    = 16'd0;
`endif

  // Reference: signed quotient in Q.8, magnitude clamped to 255, zero on divide-by-zero.
  function automatic int sval(input logic [8:0] d);
    return d[8] ? int'(d) - 512 : int'(d);
  endfunction

  function automatic logic [7:0] ref_mag(input logic [8:0] d);
    int a;
    a = (sval(d) < 0) ? -sval(d) : sval(d);
    if (a > 255) a = 255;
    return 8'(a);
  endfunction

  function automatic logic [16:0] ref_result(input logic [8:0] d, input logic [7:0] v);
    int q;
    if (v == 8'd0) return 17'd0;
    q = (int'(ref_mag(d)) * 256) / int'(v);
    if (sval(d) < 0) q = -q;
    return 17'(q);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor, scoreboard and divider stand-in ----------------
  always @(negedge clk) begin
    if (!rstn) begin
      check("reset_outputs",
            64'({bus.req_ready, bus.div_dividend_tvalid, bus.div_divisor_tvalid,
                 bus.div_dividend_tdata, bus.div_divisor_tdata, bus.rsp_valid,
                 bus.rsp_result, bus.rsp_tag, bus.rsp_dbz, bus.err_spurious}), 64'd0);
      exp_q.delete();
      credits_m  = 0;
      sb_m       = 0;
      exp_err    = 1'b0;
      pend_v     = 1'b0;
      prev_stall = 1'b0;
      for (int i = 0; i < LAT; i++) p_v[i] = 1'b0;
      spur_done  = spur_cnt;
`ifdef DIV_PERF_CNT_EN
      issued_m = 16'd0;
      dbz_m    = 16'd0;
`endif
      bus.div_dout_tvalid = 1'b0;
      bus.div_dout_tdata  = 16'd0;
      bus.div_dout_tuser  = 1'b0;
    end else begin
`ifdef DIV_PERF_CNT_EN
      check("cnt_issued", 64'(bus.cnt_issued), 64'(issued_m));
      check("cnt_dbz", 64'(bus.cnt_dbz), 64'(dbz_m));
`endif
      check("div_issue",
            64'({bus.div_dividend_tvalid, bus.div_divisor_tvalid,
                 bus.div_dividend_tdata, bus.div_divisor_tdata}),
            pend_v ? 64'({2'b11, pend_mag, pend_dvs}) : 64'd0);
      pend_v = 1'b0;
      check("err_spurious", 64'(bus.err_spurious), 64'(exp_err));
      check("req_ready", 64'(bus.req_ready), 64'(credits_m < DEPTH));
      if (prev_stall)
        check("rsp_hold", 64'({bus.rsp_valid, bus.rsp_tag, bus.rsp_dbz, bus.rsp_result}),
              64'({1'b1, prev_rsp}));
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL rsp_unexpected: got tag %0h result %0h, expected no response",
                   bus.rsp_tag, bus.rsp_result);
        end else begin
          check("rsp", 64'({bus.rsp_tag, bus.rsp_dbz, bus.rsp_result}), 64'(exp_q.pop_front()));
        end
        credits_m--;
      end
      prev_stall = bus.rsp_valid && !bus.rsp_ready;
      prev_rsp   = {bus.rsp_tag, bus.rsp_dbz, bus.rsp_result};
      if (bus.req_valid && bus.req_ready) begin
        exp_q.push_back({bus.req_tag, bus.req_divisor == 8'd0,
                         ref_result(bus.req_dividend, bus.req_divisor)});
        pend_v   = 1'b1;
        pend_mag = ref_mag(bus.req_dividend);
        pend_dvs = bus.req_divisor;
        credits_m++;
        sb_m++;
`ifdef DIV_PERF_CNT_EN
        issued_m++;
`endif
      end
      // Divider stand-in: fixed latency, quotient = (mag << 8) / divisor.
      for (int i = LAT - 1; i > 0; i--) begin
        p_v[i] = p_v[i-1];
        p_d[i] = p_d[i-1];
        p_s[i] = p_s[i-1];
      end
      p_v[0] = bus.div_dividend_tvalid && bus.div_divisor_tvalid;
      p_d[0] = bus.div_dividend_tdata;
      p_s[0] = bus.div_divisor_tdata;
      if (p_v[LAT-1]) begin
        bus.div_dout_tvalid = 1'b1;
        bus.div_dout_tuser  = (p_s[LAT-1] == 8'd0);
        bus.div_dout_tdata  = (p_s[LAT-1] == 8'd0) ? 16'($urandom) :
                              16'((int'(p_d[LAT-1]) * 256) / int'(p_s[LAT-1]));
        sb_m--;
`ifdef DIV_PERF_CNT_EN
        if (p_s[LAT-1] == 8'd0) dbz_m++;
`endif
      end else if (spur_done != spur_cnt) begin
        spur_done++;
        bus.div_dout_tvalid = 1'b1;
        bus.div_dout_tuser  = 1'b0;
        bus.div_dout_tdata  = 16'($urandom);
        if (sb_m == 0) exp_err = 1'b1;
      end else begin
        bus.div_dout_tvalid = 1'b0;
        bus.div_dout_tuser  = 1'b0;
        bus.div_dout_tdata  = 16'd0;
      end
      if (end_chk && !fin) begin
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        check("timeouts", 64'(tmo), 64'd0);
        fin = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic [8:0] d, input logic [7:0] v, input logic [TAG_W-1:0] t);
    bit acc;
    acc = 1'b0;
    bus.req_valid    = 1'b1;
    bus.req_dividend = d;
    bus.req_divisor  = v;
    bus.req_tag      = t;
    for (int i = 0; i < 500 && !acc; i++) begin
      @(negedge clk);
      acc = bus.req_ready;
      cycle();
    end
    if (!acc) tmo++;
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) cycle();
    if (exp_q.size() != 0) tmo++;
    repeat (4) cycle();
  endtask

  function automatic logic [8:0] rand_dividend();
    return ($urandom_range(0, 9) == 0) ? 9'h100 : 9'($urandom_range(0, 511));
  endfunction

  function automatic logic [7:0] rand_divisor();
    return ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
  endfunction

  // ---------------- stimulus ----------------
  bit rand_done;

  initial begin
    bus.req_valid    = 1'b0;
    bus.req_dividend = 9'd0;
    bus.req_divisor  = 8'd0;
    bus.req_tag      = '0;
    bus.rsp_ready    = 1'b0;
    #1 rstn = 1'b0;
    repeat (3) cycle();
    rstn = 1'b1;
    cycle();

    // Directed cases, back-to-back.
    bus.rsp_ready = 1'b1;
    send_req(9'd1,   8'd2,   4'd3);
    send_req(9'h1F8, 8'd8,   4'd5);
    send_req(9'd3,   8'd0,   4'd6);
    send_req(9'h100, 8'd255, 4'd7);
    send_req(9'd1,   8'd1,   4'd8);
    send_req(9'd1,   8'd3,   4'd9);
    send_req(9'd5,   8'd2,   4'd10);
    drain();

    // Backpressure: 10 requests against a stalled consumer.
    bus.rsp_ready = 1'b0;
    fork
      for (int i = 0; i < 10; i++) send_req(rand_dividend(), 8'($urandom_range(1, 255)), 4'(i));
      begin
        repeat (40) cycle();
        bus.rsp_ready = 1'b1;
      end
    join
    drain();

    // Random traffic with random consumer stalls.
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) cycle();
          send_req(rand_dividend(), rand_divisor(), 4'($urandom_range(0, 15)));
        end
        rand_done = 1'b1;
      end
      begin
        for (int i = 0; i < 20000 && !rand_done; i++) begin
          bus.rsp_ready = ($urandom_range(0, 2) != 0);
          cycle();
        end
        bus.rsp_ready = 1'b1;
      end
    join
    drain();

    // Spurious divider result with nothing pending.
    spur_cnt++;
    repeat (10) cycle();

    // Reset with three ops in flight.
    bus.rsp_ready = 1'b0;
    send_req(9'd7, 8'd3, 4'd1);
    send_req(9'h1F0, 8'd5, 4'd2);
    send_req(9'd100, 8'd9, 4'd4);
    repeat (2) cycle();
    rstn = 1'b0;
    repeat (3) cycle();
    rstn = 1'b1;
    bus.rsp_ready = 1'b1;
    repeat (20) cycle();

    end_chk = 1'b1;
    for (int i = 0; i < 10 && !fin; i++) cycle();
    if (!fin) $display("FAIL end_check: monitor did not complete final checks");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
